// File: rtl/pic_pkg.sv
// Shared decode constants and types for the wb_pic8 interrupt controller.
package pic_pkg;

  typedef logic [2:0] prio_idx_t;

  localparam logic [2:0] OCW_EOI_NS = 3'b001;
  localparam logic [2:0] OCW_EOI_SP = 3'b011;
  localparam logic [1:0] OCW3_TAG   = 2'b01;

  localparam logic RSEL_IRR = 1'b0;
  localparam logic RSEL_ISR = 1'b1;

endpackage

// File: rtl/pic_prio_enc.sv
// 8-bit priority encoder; bit 0 has the highest priority.
module pic_prio_enc
  import pic_pkg::*;
(
  input  logic [7:0] vec_i,
  output logic       valid_o,
  output prio_idx_t  idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    // scan downward so the lowest set index is the last one written
    for (int i = 7; i >= 0; i--) begin
      if (vec_i[i]) idx_o = prio_idx_t'(i);
    end
  end

endmodule

// File: rtl/wb_pic8.sv
// 8-input fixed-priority interrupt controller (8259 subset) with a one-word
// Wishbone slave for IMR, EOI/OCW3 and IRR/ISR readback.
module wb_pic8
  import pic_pkg::*;
#(
  parameter logic [7:0] VEC_BASE = 8'h08,
  parameter logic [7:0] IMR_RST  = 8'h00
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [15:0] wb_dat_i,
  output logic [15:0] wb_dat_o,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  input  logic [7:0]  irq_i,
  output logic        intr_o,
  input  logic        inta_i,
  output logic [7:0]  vec_o
);

  logic [7:0]  irr_q, irr_d, isr_q, isr_d, imr_q, imr_d;
  logic        rsel_q, rsel_d;
  logic [7:0]  irq_q;
  logic        inta_q;
  logic        ack_q, ack_d;
  logic [15:0] dat_q, dat_d;
  logic        intr_q, intr_d;
  logic [7:0]  vec_q, vec_d;

  logic [7:0]  req, rise, eoi_clr, inta_set;
  logic        req_v, isr_v, access, ocw_wr, imr_wr, inta_edge;
  prio_idx_t   p, s;

  assign req = irr_q & ~imr_q;

  pic_prio_enc u_req_enc (.vec_i(req),   .valid_o(req_v), .idx_o(p));
  pic_prio_enc u_isr_enc (.vec_i(isr_q), .valid_o(isr_v), .idx_o(s));

  always_comb begin
    access    = wb_stb_i & wb_cyc_i & ~ack_q;
    ocw_wr    = access & wb_we_i & wb_sel_i[0];
    imr_wr    = access & wb_we_i & wb_sel_i[1];
    rise      = irq_i & ~irq_q;
    inta_edge = inta_i & ~inta_q;
    eoi_clr   = '0;
    inta_set  = '0;
    rsel_d    = rsel_q;
    vec_d     = vec_q;

    // bit 4 set is ICW1, which this controller ignores
    if (ocw_wr && !wb_dat_i[4]) begin
      if (wb_dat_i[4:3] == OCW3_TAG) begin
        if (wb_dat_i[1]) rsel_d = wb_dat_i[0];
      end else if (wb_dat_i[7:5] == OCW_EOI_SP) begin
        eoi_clr[wb_dat_i[2:0]] = 1'b1;
      end else if (((wb_dat_i[7:5] & OCW_EOI_NS) == OCW_EOI_NS) && isr_v) begin
        eoi_clr[s] = 1'b1;
      end
    end

    if (inta_edge) begin
      if (req_v) begin
        inta_set[p] = 1'b1;
        vec_d       = {VEC_BASE[7:3], p};
      end else begin
        vec_d = {VEC_BASE[7:3], 3'd7};
      end
    end

    // EOI works on the pre-inta ISR; a fresh edge beats the inta clear
    irr_d  = (irr_q & ~inta_set) | rise;
    isr_d  = (isr_q & ~eoi_clr) | inta_set;
    imr_d  = imr_wr ? wb_dat_i[15:8] : imr_q;
    ack_d  = access;
    dat_d  = (access && !wb_we_i) ? {imr_q, (rsel_q == RSEL_ISR) ? isr_q : irr_q} : dat_q;
    intr_d = req_v && (!isr_v || (p < s));
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      irr_q  <= '0;
      isr_q  <= '0;
      imr_q  <= IMR_RST;
      rsel_q <= RSEL_IRR;
      irq_q  <= '0;
      inta_q <= 1'b0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      intr_q <= 1'b0;
      vec_q  <= {VEC_BASE[7:3], 3'd7};
    end else begin
      irr_q  <= irr_d;
      isr_q  <= isr_d;
      imr_q  <= imr_d;
      rsel_q <= rsel_d;
      irq_q  <= irq_i;
      inta_q <= inta_i;
      ack_q  <= ack_d;
      dat_q  <= dat_d;
      intr_q <= intr_d;
      vec_q  <= vec_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign intr_o   = intr_q;
  assign vec_o    = vec_q;

endmodule

// File: tb/tb_wb_pic8.sv
// Directed bench for wb_pic8: nesting, EOI, masking, OCW3 readback, spurious inta, reset.
module tb_wb_pic8;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic [15:0] wb_dat_i, wb_dat_o;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
  logic [1:0]  wb_sel_i;
  logic [7:0]  irq_i, vec_o;
  logic        intr_o, inta_i;
  logic [15:0] rd;
  int checks = 0;
  int errors = 0;

  always #5 clk_sys = ~clk_sys;

  wb_pic8 dut (
    .wb_clk_i(clk_sys), .wb_rst_ni(rst_n),
    .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i),
    .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .irq_i(irq_i), .intr_o(intr_o), .inta_i(inta_i), .vec_o(vec_o)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] sel, input logic [15:0] dat,
                         output logic [15:0] rdat);
    bit acked = 0;
    wb_we_i  = we;
    wb_sel_i = sel;
    wb_dat_i = dat;
    wb_stb_i = 1'b1;
    wb_cyc_i = 1'b1;
    for (int n = 0; n < 4 && !acked; n++) begin
      tick(1);
      if (wb_ack_o) acked = 1;
    end
    rdat     = wb_dat_o;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    wb_we_i  = 1'b0;
    if (!acked) check("ack_timeout", 16'h0, 16'h1);
  endtask

  task automatic wb_wr(input logic [1:0] sel, input logic [15:0] dat);
    logic [15:0] dummy;
    wb_xfer(1'b1, sel, dat, dummy);
  endtask

  task automatic wb_rd(output logic [15:0] rdat);
    wb_xfer(1'b0, 2'b11, 16'h0, rdat);
  endtask

  // one-cycle inta pulse; vec_o is valid on return
  task automatic do_inta();
    inta_i = 1'b1;
    tick(1);
    inta_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    wb_dat_i = '0; wb_we_i = 0; wb_sel_i = '0; wb_stb_i = 0; wb_cyc_i = 0;
    irq_i = '0; inta_i = 0;
    #12;
    check("rst_ack", {15'h0, wb_ack_o}, 16'h0);
    check("rst_intr", {15'h0, intr_o}, 16'h0);
    check("rst_dat", wb_dat_o, 16'h0000);
    check("rst_vec", {8'h0, vec_o}, 16'h000F);
    rst_n = 1'b1;
    tick(2);

    // 1: single request and acknowledge
    irq_i = 8'h01;
    tick(1);
    check("t1_intr_1cyc", {15'h0, intr_o}, 16'h0);
    tick(1);
    check("t1_intr_2cyc", {15'h0, intr_o}, 16'h1);
    do_inta();
    check("t1_vec", {8'h0, vec_o}, 16'h0008);
    tick(1);
    check("t1_intr_after", {15'h0, intr_o}, 16'h0);
    wb_rd(rd);
    check("t1_irr", rd, 16'h0000);
    wb_wr(2'b01, 16'h000B);
    wb_rd(rd);
    check("t1_isr", rd, 16'h0001);

    // 2: nesting a higher priority request under ISR[1]
    wb_wr(2'b01, 16'h0020);
    irq_i = 8'h03;
    tick(2);
    check("t2_intr_irq1", {15'h0, intr_o}, 16'h1);
    do_inta();
    check("t2_vec_irq1", {8'h0, vec_o}, 16'h0009);
    tick(1);
    check("t2_intr_idle", {15'h0, intr_o}, 16'h0);
    irq_i = 8'h02;
    tick(1);
    irq_i = 8'h03;
    tick(2);
    check("t2_intr_nest", {15'h0, intr_o}, 16'h1);
    do_inta();
    check("t2_vec_irq0", {8'h0, vec_o}, 16'h0008);
    wb_rd(rd);
    check("t2_isr", rd, 16'h0003);

    // 3: non-specific EOIs, the last one a no-op; ICW1 is ignored
    wb_wr(2'b01, 16'h0020);
    wb_rd(rd);
    check("t3_eoi1", rd, 16'h0002);
    wb_wr(2'b01, 16'h0020);
    wb_rd(rd);
    check("t3_eoi2", rd, 16'h0000);
    wb_wr(2'b01, 16'h0020);
    wb_wr(2'b01, 16'h0013);
    wb_rd(rd);
    check("t3_eoi3", rd, 16'h0000);

    // 4: masking holds IRR but blocks intr_o
    wb_wr(2'b10, 16'h0200);
    irq_i = 8'h01;
    tick(1);
    irq_i = 8'h03;
    tick(3);
    check("t4_masked", {15'h0, intr_o}, 16'h0);
    wb_wr(2'b01, 16'h000A);
    wb_rd(rd);
    check("t4_irr_imr", rd, 16'h0202);
    wb_wr(2'b10, 16'h0000);
    tick(1);
    check("t4_unmasked", {15'h0, intr_o}, 16'h1);
    do_inta();
    check("t4_vec", {8'h0, vec_o}, 16'h0009);

    // 5: ISR readback, spurious inta, specific EOI
    wb_wr(2'b01, 16'h000B);
    wb_rd(rd);
    check("t5_isr", rd, 16'h0002);
    check("t5_intr", {15'h0, intr_o}, 16'h0);
    do_inta();
    check("t5_spurious_vec", {8'h0, vec_o}, 16'h000F);
    wb_rd(rd);
    check("t5_isr_same", rd, 16'h0002);
    wb_wr(2'b01, 16'h0061);
    wb_rd(rd);
    check("t5_specific_eoi", rd, 16'h0000);

    // 6: reset while inta_i is high with all lines pending
    irq_i = 8'h00;
    tick(1);
    irq_i = 8'hFF;
    tick(2);
    check("t6_intr", {15'h0, intr_o}, 16'h1);
    inta_i = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_intr", {15'h0, intr_o}, 16'h0);
    check("t6_rst_vec", {8'h0, vec_o}, 16'h000F);
    check("t6_rst_ack", {15'h0, wb_ack_o}, 16'h0);
    check("t6_rst_dat", wb_dat_o, 16'h0000);
    tick(2);
    inta_i = 1'b0;
    irq_i  = 8'h00;
    rst_n  = 1'b1;
    tick(2);
    wb_rd(rd);
    check("t6_irr_clear", rd, 16'h0000);
    check("t6_vec_after", {8'h0, vec_o}, 16'h000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
